// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface mips_mc_controller_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Op;
    logic [5:0]         Funct;
    logic               Zero;
    logic               IorD;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSrc;
    logic               PCEn;
    logic [2:0]         ALUControl;
    logic [STATE_W-1:0] state_dbg;
    logic               illegal_op;

    modport master (
        input  Op, Funct, Zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, state_dbg, illegal_op
    );

    modport slave (
        output Op, Funct, Zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, state_dbg, illegal_op
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore main FSM, R-type ALU decoder and
// a sticky flag for unsupported opcodes or function codes.
module mips_mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mips_mc_controller_if.master  bus
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        EXECUTE = STATE_W'(6),
        ALUWB   = STATE_W'(7),
        BEQEX   = STATE_W'(8),
        ADDIEX  = STATE_W'(9),
        ADDIWB  = STATE_W'(10),
        JEX     = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state;
    state_t     next_state;
    logic [2:0] funct_alu;
    logic       funct_legal;
    logic       pc_write;
    logic       branch;
    logic       illegal_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Decoding from DECODE covers every Op; anything unknown restarts fetch.
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (bus.Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = MEMWB;
            EXECUTE: next_state = ALUWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        funct_alu   = ALU_ADD;
        funct_legal = 1'b1;
        case (bus.Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100110: funct_alu = ALU_XOR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    // Sticky: an unknown Op is caught leaving DECODE, an unknown Funct leaving EXECUTE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if ((state == DECODE && next_state == FETCH) ||
                     (state == EXECUTE && !funct_legal)) begin
            illegal_q <= 1'b1;
        end
    end

    always_comb begin
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.ALUControl = ALU_ADD;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (state)
            FETCH: begin
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = 1'b1;
                pc_write    = 1'b1;
            end
            DECODE:  bus.ALUSrcB = 2'b11;
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD:   bus.IorD = 1'b1;
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXECUTE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = funct_alu;
            end
            ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            BEQEX: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = ALU_SUB;
                bus.PCSrc      = 2'b01;
                branch         = 1'b1;
            end
            ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            ADDIWB:  bus.RegWrite = 1'b1;
            JEX: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        bus.PCEn = pc_write | (branch & bus.Zero);
        // Held reset must never let a write or PC load slip through.
        if (!reset_n) begin
            bus.IorD       = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.RegDst     = 1'b0;
            bus.MemtoReg   = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.ALUSrcA    = 1'b0;
            bus.ALUSrcB    = 2'b00;
            bus.PCSrc      = 2'b00;
            bus.ALUControl = 3'b000;
            bus.PCEn       = 1'b0;
        end
    end

    assign bus.state_dbg  = state;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized self-checking bench for mips_mc_controller, compared against a
// per-instruction state-path and per-state control-word reference model.
module tb_mips_mc_controller;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    int         path[$];
    logic       opKnown;
    logic       modelIllegal;
    logic [2:0] functMap [logic [5:0]];
    logic [5:0] legalOps [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] legalFuncts [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};

    mips_mc_controller_if #(.STATE_W(4)) bus ();

    mips_mc_controller #(.STATE_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [14:0] obsCtrl;
    assign obsCtrl = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                      bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.PCEn, bus.ALUControl};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Each instruction class is a fixed list of visited states.
    function automatic void buildPath(input logic [5:0] op);
        path.delete();
        opKnown = 1'b1;
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
            6'b001000: path = '{0, 1, 9, 10};
            6'b000010: path = '{0, 1, 11};
            default: begin
                path    = '{0, 1};
                opKnown = 1'b0;
            end
        endcase
    endfunction

    function automatic logic [14:0] expectedCtrl(input int st, input logic [5:0] funct, input logic zero);
        logic       iord = 0, memw = 0, irw = 0, regdst = 0, mtr = 0, regw = 0, srca = 0, pcen = 0;
        logic [1:0] srcb = 2'b00, pcsrc = 2'b00;
        logic [2:0] alu = 3'b010;
        case (st)
            0:  begin srcb = 2'b01; irw = 1; pcen = 1; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  iord = 1;
            4:  begin mtr = 1; regw = 1; end
            5:  begin iord = 1; memw = 1; end
            6:  begin srca = 1; alu = functMap.exists(funct) ? functMap[funct] : 3'b010; end
            7:  begin regdst = 1; regw = 1; end
            8:  begin srca = 1; alu = 3'b110; pcsrc = 2'b01; pcen = zero; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: regw = 1;
            11: begin pcsrc = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {iord, memw, irw, regdst, mtr, regw, srca, srcb, pcsrc, pcen, alu};
    endfunction

    task automatic stepCheck(input logic [5:0] op, input logic [5:0] funct, input int st, input logic zero);
        bus.Zero = zero;
        #1;
        checkOutput($sformatf("op=%b st=%0d state", op, st), 32'(bus.state_dbg), 32'(st));
        checkOutput($sformatf("op=%b st=%0d ctrl", op, st), 32'(obsCtrl), 32'(expectedCtrl(st, funct, zero)));
        checkOutput($sformatf("op=%b st=%0d illegal", op, st), 32'(bus.illegal_op), 32'(modelIllegal));
    endtask

    // zmode 0/1 holds Zero constant for the whole instruction, 2 randomizes it per cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct, input int zmode);
        logic zero;
        bus.Op    = op;
        bus.Funct = funct;
        buildPath(op);
        foreach (path[i]) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            stepCheck(op, funct, path[i], zero);
            @(posedge clk);
            if (path[i] == 1 && !opKnown) modelIllegal = 1'b1;
            if (path[i] == 6 && !functMap.exists(funct)) modelIllegal = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic midResetCheck();
        bus.Op    = 6'b101011;
        bus.Funct = 6'($urandom);
        stepCheck(bus.Op, bus.Funct, 0, 1'b0);
        @(negedge clk);
        stepCheck(bus.Op, bus.Funct, 1, 1'b0);
        @(negedge clk);
        stepCheck(bus.Op, bus.Funct, 2, 1'b0);
        @(negedge clk);
        stepCheck(bus.Op, bus.Funct, 5, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset ctrl", 32'(obsCtrl), 32'd0);
        checkOutput("midreset state held", 32'(bus.state_dbg), 32'd5);
        @(posedge clk);
        #1;
        modelIllegal = 1'b0;
        checkOutput("midreset state", 32'(bus.state_dbg), 32'd0);
        checkOutput("midreset illegal", 32'(bus.illegal_op), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] funct;
        functMap[6'b100000] = 3'b010;
        functMap[6'b100010] = 3'b110;
        functMap[6'b100100] = 3'b000;
        functMap[6'b100101] = 3'b001;
        functMap[6'b100110] = 3'b100;
        functMap[6'b101010] = 3'b111;
        modelIllegal = 1'b0;
        reset_n      = 1'b0;
        bus.Op       = 6'($urandom);
        bus.Funct    = 6'($urandom);
        bus.Zero     = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset state", 32'(bus.state_dbg), 32'd0);
        checkOutput("reset ctrl", 32'(obsCtrl), 32'd0);
        checkOutput("reset illegal", 32'(bus.illegal_op), 32'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("release fetch ctrl", 32'(obsCtrl), 32'(expectedCtrl(0, 6'd0, 1'b1)));

        applyStimulus(6'b100011, 6'b000000, 2);
        applyStimulus(6'b000000, 6'b100010, 2);
        applyStimulus(6'b000000, 6'b101010, 2);
        applyStimulus(6'b000000, 6'b100110, 2);
        applyStimulus(6'b000100, 6'b000000, 1);
        applyStimulus(6'b000100, 6'b000000, 0);
        applyStimulus(6'b001000, 6'b000000, 2);
        applyStimulus(6'b000010, 6'b000000, 2);
        applyStimulus(6'b111111, 6'b000000, 2);
        applyStimulus(6'b101011, 6'b000000, 2);
        applyStimulus(6'b000000, 6'b000000, 2);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 8) op = legalOps[$urandom_range(0, 5)];
            else                          op = 6'($urandom);
            if ($urandom_range(0, 9) < 8) funct = legalFuncts[$urandom_range(0, 5)];
            else                          funct = 6'($urandom);
            applyStimulus(op, funct, 2);
        end

        midResetCheck();
        applyStimulus(6'b100011, 6'b000000, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
